pdm_transmitter: RTL and testbench

//  Output-side counterpart of the PDM microphone receiver. Accepts signed PCM samples over a

---
 rtl/pdm_transmitter_if.sv | 12 +
 rtl/pdm_transmitter.sv | 118 +++++++++++
 tb/tb_pdm_transmitter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_transmitter_if.sv
// PCM sample handshake into the PDM transmitter: signed sample, valid, ready.
// The master drives samples; the transmitter is the slave.
interface pdm_transmitter_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] pcm_data;
   logic                     pcm_valid;
   logic                     pcm_ready;

   modport master (output pcm_data, output pcm_valid, input pcm_ready);
   modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_transmitter.sv
// PCM-to-PDM transmitter: one-entry sample buffer, bit-clock divider, first-order sigma-delta.
// Optional macro PDM_UNDERRUN_CNT_EN adds an 8-bit saturating underrun counter port.
module pdm_transmitter #(
   parameter int CLK_DIV = 50,
   parameter int OSR     = 64,
   parameter int DATA_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   pdm_transmitter_if.slave   s_pcm,
   output logic               pdm_clk,
   output logic               pdm_data,
   output logic               pdm_en,
   output logic               underrun
`ifdef PDM_UNDERRUN_CNT_EN
   ,
   output logic [7:0]         underrun_cnt
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

   // Sign-bit flip maps signed PCM onto 0..2^DATA_W-1 so midscale gives 50% ones density.
   function automatic logic [DATA_W-1:0] to_offset_bin(input logic signed [DATA_W-1:0] s);
      return {~s[DATA_W-1], s[DATA_W-2:0]};
   endfunction

   logic [DIV_W-1:0]         r_div_cnt;
   logic                     r_pdm_clk;
   logic [BIT_W-1:0]         r_bit_cnt;
   logic signed [DATA_W-1:0] r_buf_p0;
   logic                     r_buf_full;
   logic signed [DATA_W-1:0] r_cur_p1;
   logic [DATA_W-1:0]        r_acc;
   logic                     r_pdm_data;
   logic                     r_pdm_en;
   logic                     r_underrun;

   logic                     w_accept;
   logic                     w_div_wrap;
   logic                     w_fall_tick;
   logic                     w_boundary;
   logic                     w_load;
   logic                     w_underrun_evt;
   logic [DATA_W:0]          w_sum;

   assign s_pcm.pcm_ready = reset & ~r_buf_full;
   assign w_accept        = s_pcm.pcm_valid & s_pcm.pcm_ready;
   assign w_div_wrap      = (r_div_cnt == DIV_LAST);
   assign w_fall_tick     = w_div_wrap & r_pdm_clk;
   assign w_boundary      = w_fall_tick & (r_bit_cnt == BIT_LAST);
   assign w_load          = w_boundary & r_buf_full;
   assign w_underrun_evt  = w_boundary & ~r_buf_full & r_pdm_en;
   assign w_sum           = {1'b0, r_acc} + {1'b0, to_offset_bin(r_cur_p1)};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_div_cnt  <= '0;
         r_pdm_clk  <= 1'b0;
         r_bit_cnt  <= '0;
         r_buf_p0   <= '0;
         r_buf_full <= 1'b0;
         r_cur_p1   <= '0;
         r_acc      <= '0;
         r_pdm_data <= 1'b0;
         r_pdm_en   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_div_cnt  <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
         r_underrun <= w_underrun_evt;
         if (w_div_wrap)
            r_pdm_clk <= ~r_pdm_clk;
         // Stage p0 -> p1: buffered sample becomes the modulated sample at the frame boundary.
         if (w_fall_tick) begin
            r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
            if (r_pdm_en) begin
               r_pdm_data <= w_sum[DATA_W];
               r_acc      <= w_sum[DATA_W-1:0];
            end
         end
         if (w_load) begin
            r_cur_p1   <= r_buf_p0;
            r_buf_full <= 1'b0;
            r_pdm_en   <= 1'b1;
         end
         if (w_accept) begin
            r_buf_p0   <= s_pcm.pcm_data;
            r_buf_full <= 1'b1;
         end
      end
   end

`ifdef PDM_UNDERRUN_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] r_underrun_cnt;

   always_ff @(posedge clk) begin
      if (!reset)
         r_underrun_cnt <= '0;
      else if (w_underrun_evt)
         r_underrun_cnt <= sat_inc8(r_underrun_cnt);
   end

   assign underrun_cnt = r_underrun_cnt;
`endif

   assign pdm_clk  = r_pdm_clk;
   assign pdm_data = r_pdm_data;
   assign pdm_en   = r_pdm_en;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_pdm_transmitter.sv
// Randomized self-checking bench for pdm_transmitter against a cycle-indexed arithmetic model.
// Define PDM_UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_pdm_transmitter;

   localparam int CLK_DIV = 2;
   localparam int OSR     = 8;
   localparam int DATA_W  = 16;
   localparam int FRAME   = 2 * CLK_DIV * OSR;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pdm_clk, pdm_data, pdm_en, underrun;
`ifdef PDM_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   pdm_transmitter_if #(.DATA_W(DATA_W)) pif ();

   pdm_transmitter #(.CLK_DIV(CLK_DIV), .OSR(OSR), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .s_pcm    (pif),
      .pdm_clk  (pdm_clk),
      .pdm_data (pdm_data),
      .pdm_en   (pdm_en),
      .underrun (underrun)
`ifdef PDM_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: cycle count since release, tick index, sample buffer, modulator.
   int m_c = 0, m_k = 0;
   bit m_tick = 0, m_clk = 0, m_data = 0, m_en = 0, m_und = 0, m_full = 0;
   int m_buf = 0, m_cur = 0, m_acc = 0, m_cnt = 0;
   int m_load_c[$];
   int m_load_k[$];
   int dut_acc_c[$];
   int n_und_obs = 0;
   logic obs [0:8191];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [7:0] frame_bits(input int start);
      logic [7:0] r;
      r = '0;
      for (int i = 1; i <= OSR; i++)
         if (start + i < 8192) r = {r[6:0], obs[start + i]};
      return r;
   endfunction

   task automatic step();
      bit m_acc_now, d_acc_now;
      int u, s;
      m_acc_now = rst_n && pif.pcm_valid && !m_full;
      d_acc_now = pif.pcm_valid && pif.pcm_ready;
      @(posedge clk);
      if (!rst_n) begin
         m_c = 0; m_k = 0; m_tick = 0; m_clk = 0; m_data = 0; m_en = 0; m_und = 0;
         m_full = 0; m_buf = 0; m_cur = 0; m_acc = 0; m_cnt = 0;
      end else begin
         m_c++;
         m_tick = 0;
         m_und  = 0;
         m_clk  = ((m_c / CLK_DIV) % 2) == 1;
         if (m_c % (2 * CLK_DIV) == 0) begin
            m_tick = 1;
            m_k = m_c / (2 * CLK_DIV);
            if (m_en) begin
               u = m_cur + 32768;
               s = m_acc + u;
               m_data = (s >= 65536);
               m_acc = s % 65536;
            end
            if (m_k % OSR == 0) begin
               if (m_full) begin
                  m_cur = m_buf; m_full = 0; m_en = 1;
                  m_load_c.push_back(m_c);
                  m_load_k.push_back(m_k);
               end else if (m_en) begin
                  m_und = 1;
                  if (m_cnt < 255) m_cnt++;
               end
            end
         end
         if (m_acc_now) begin
            m_buf = int'(pif.pcm_data);
            m_full = 1;
         end
         if (d_acc_now) dut_acc_c.push_back(m_c);
      end
      #1;
      if (m_tick && m_k < 8192) obs[m_k] = pdm_data;
      if (underrun === 1'b1) n_und_obs++;
      check("pdm_clk",   pdm_clk,       m_clk);
      check("pdm_data",  pdm_data,      m_data);
      check("pdm_en",    pdm_en,        m_en);
      check("underrun",  underrun,      m_und);
      check("pcm_ready", pif.pcm_ready, rst_n && !m_full);
`ifdef PDM_UNDERRUN_CNT_EN
      check("underrun_cnt", underrun_cnt, m_cnt);
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Leaves pcm_valid high so back-to-back sends keep it asserted.
   task automatic send(input logic [15:0] d);
      bit done;
      done = 0;
      pif.pcm_data  = d;
      pif.pcm_valid = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
         if (pif.pcm_ready === 1'b1) done = 1;
         step();
      end
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic wait_loads(input int n);
      int target;
      target = m_load_c.size() + n;
      for (int i = 0; i < 50 * FRAME && m_load_c.size() < target; i++) step();
      if (m_load_c.size() < target) check("load_timeout", 0, 1);
   endtask

   initial begin
      int kA, kB, u0, a0, l0, c0, ones;
      pif.pcm_data  = '0;
      pif.pcm_valid = 1'b0;

      // Reset state and divider start-up
      rst_n = 1'b0;
      run(10);
      check("rst_outs", {pdm_clk, pdm_data, pdm_en, underrun, pif.pcm_ready}, 5'b0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", pif.pcm_ready, 1'b1);

      // Single midscale sample, then starvation
      send(16'h0000);
      pif.pcm_valid = 1'b0;
      wait_loads(1);
      kA = m_load_k[$];
      run(3 * FRAME);
      check("t2_frame1", frame_bits(kA), 8'h55);
      check("t2_frame2", frame_bits(kA + OSR), 8'h55);
      u0 = n_und_obs;
      run(2 * FRAME);
      check("t2_underruns", n_und_obs - u0, 2);

      // Near full scale then negative full scale, accumulator carried over
      send(16'h7FFF);
      send(16'h8000);
      pif.pcm_valid = 1'b0;
      kA = m_load_k[$];
      wait_loads(1);
      kB = m_load_k[$];
      run(FRAME);
      check("t3_frameA", frame_bits(kA), 8'h7F);
      check("t3_frameB", frame_bits(kB), 8'h00);

      // Valid held high across three random samples
      a0 = dut_acc_c.size();
      l0 = m_load_c.size();
      c0 = m_c;
      send(16'($urandom));
      send(16'($urandom));
      send(16'($urandom));
      pif.pcm_valid = 1'b0;
      wait_loads(3 - (m_load_c.size() - l0));
      check("t4_nacc", dut_acc_c.size() - a0, 3);
      check("t4_acc0", dut_acc_c[a0], c0 + 1);
      check("t4_acc1", dut_acc_c[a0 + 1], m_load_c[l0] + 1);
      check("t4_acc2", dut_acc_c[a0 + 2], m_load_c[l0 + 1] + 1);
      run(FRAME);

      // Reset mid-frame with the buffer full
      send(16'h7000);
      pif.pcm_valid = 1'b0;
      run(5);
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      step();
      check("t5_en", pdm_en, 1'b0);
      check("t5_ready", pif.pcm_ready, 1'b1);
      ones = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if (pdm_data === 1'b1) ones++;
      end
      check("t5_ones", ones, 0);
      check("t5_en_idle", pdm_en, 1'b0);
      send(16'h0000);
      pif.pcm_valid = 1'b0;
      wait_loads(1);
      check("t5_en_new", pdm_en, 1'b1);

      // Random samples with random gaps
      for (int i = 0; i < 10; i++) begin
         run($urandom_range(0, 40));
         send(16'($urandom));
         pif.pcm_valid = 1'b0;
      end
      run(2 * FRAME);

`ifdef PDM_UNDERRUN_CNT_EN
      // Underrun counter saturation
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      send(16'h1234);
      pif.pcm_valid = 1'b0;
      wait_loads(1);
      run(300 * FRAME);
      check("t6_cnt", underrun_cnt, 8'hFF);
      run(2 * FRAME);
      check("t6_cnt_hold", underrun_cnt, 8'hFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
